// File: rtl/glitch_pkg.sv
// Shared types and default widths for the glitch sweep sequencer slice.
package glitch_pkg;

  localparam int W_DEFAULT     = 32;
  localparam int REP_W_DEFAULT = 8;
  localparam int COOL_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_COOL = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } sweep_state_t;

endpackage

// File: rtl/sweep_axis.sv
// One sweep axis: shadows start/end/step on init and walks the current value.
// A zero step is stored as 1. wrap means the next advance would pass the end
// (or carry out of W bits), in which case advance returns the value to start.
module sweep_axis #(
  parameter int W = 32
) (
  input  logic         i_PLL_Clk,
  input  logic         i_Rst_L,
  input  logic         init,
  input  logic         advance,
  input  logic [W-1:0] start_in,
  input  logic [W-1:0] end_in,
  input  logic [W-1:0] step_in,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] start_reg;
  logic [W-1:0] end_reg;
  logic [W-1:0] step_reg;
  logic [W-1:0] value_reg;
  logic [W:0]   sum;

  // The sum is one bit wider so a carry out of W bits is seen as a wrap.
  assign sum   = {1'b0, value_reg} + {1'b0, step_reg};
  assign wrap  = sum[W] || (sum[W-1:0] > end_reg);
  assign value = value_reg;

  // Shadow the axis configuration on init; step or wrap on advance.
  always_ff @(posedge i_PLL_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      start_reg <= '0;
      end_reg   <= '0;
      step_reg  <= '0;
      value_reg <= '0;
    end else if (init) begin
      start_reg <= start_in;
      end_reg   <= end_in;
      step_reg  <= (step_in == '0) ? W'(1) : step_in;
      value_reg <= start_in;
    end else if (advance) begin
      value_reg <= wrap ? start_reg : sum[W-1:0];
    end
  end

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// Glitch sweep sequencer: walks the (delay, duration) grid, loading and arming
// the pulse engine for each attempt. Delay is the inner loop.
// Optional build macro GLITCH_SWEEP_TIMEOUT_EN adds a per-attempt WAIT timeout
// (i_timeout / o_timeout_cnt).
module glitch_sweep_sequencer
  import glitch_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int REP_W  = REP_W_DEFAULT,
  parameter int COOL_W = COOL_W_DEFAULT
) (
  input  logic              i_PLL_Clk,
  input  logic              i_Rst_L,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [W-1:0]      i_delay_start,
  input  logic [W-1:0]      i_delay_end,
  input  logic [W-1:0]      i_delay_step,
  input  logic [W-1:0]      i_dur_start,
  input  logic [W-1:0]      i_dur_end,
  input  logic [W-1:0]      i_dur_step,
  input  logic [REP_W-1:0]  i_repeat,
  input  logic [COOL_W-1:0] i_cooldown,
  input  logic              i_pulse_fired,
`ifdef GLITCH_SWEEP_TIMEOUT_EN
  input  logic [W-1:0]      i_timeout,
  output logic [W-1:0]      o_timeout_cnt,
`endif
  output logic [W-1:0]      o_glitch_delay,
  output logic [W-1:0]      o_glitch_duration,
  output logic              o_load,
  output logic              o_arm,
  output logic              o_busy,
  output logic              o_done,
  output logic [W-1:0]      o_attempts
);

  sweep_state_t      state_reg;
  logic [REP_W-1:0]  rep_reg;
  logic [REP_W-1:0]  repeat_reg;
  logic [COOL_W-1:0] cool_reg;
  logic [COOL_W-1:0] cool_cnt_reg;
  logic [W-1:0]      attempts_reg;
  logic              fired_prev_reg;

  logic start_accept;
  logic in_next;
  logic delay_adv;
  logic dur_adv;
  logic delay_wrap;
  logic dur_wrap;
  logic fire_edge;
  logic timeout_hit;

  assign start_accept = i_start && !i_abort &&
                        ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign in_next      = (state_reg == S_NEXT) && !i_abort;
  // When both axes wrap the sweep ends, so neither moves and DONE shows the last point.
  assign delay_adv    = in_next && !(delay_wrap && dur_wrap);
  assign dur_adv      = in_next && delay_wrap && !dur_wrap;
  // A level already high when WAIT is entered has a high previous value, so it never counts.
  assign fire_edge    = i_pulse_fired && !fired_prev_reg;

  sweep_axis #(.W(W)) u_delay_axis (
    .i_PLL_Clk (i_PLL_Clk),
    .i_Rst_L   (i_Rst_L),
    .init      (start_accept),
    .advance   (delay_adv),
    .start_in  (i_delay_start),
    .end_in    (i_delay_end),
    .step_in   (i_delay_step),
    .value     (o_glitch_delay),
    .wrap      (delay_wrap)
  );

  sweep_axis #(.W(W)) u_dur_axis (
    .i_PLL_Clk (i_PLL_Clk),
    .i_Rst_L   (i_Rst_L),
    .init      (start_accept),
    .advance   (dur_adv),
    .start_in  (i_dur_start),
    .end_in    (i_dur_end),
    .step_in   (i_dur_step),
    .value     (o_glitch_duration),
    .wrap      (dur_wrap)
  );

`ifdef GLITCH_SWEEP_TIMEOUT_EN
  logic [W-1:0] timeout_reg;
  logic [W-1:0] wait_cnt_reg;
  logic [W-1:0] tmo_cnt_reg;

  assign timeout_hit   = (timeout_reg != '0) && ((wait_cnt_reg + W'(1)) == timeout_reg);
  assign o_timeout_cnt = tmo_cnt_reg;

  // Count WAIT cycles and tally attempts that expired without a pulse edge.
  always_ff @(posedge i_PLL_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      timeout_reg  <= '0;
      wait_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
    end else begin
      if (start_accept) begin
        timeout_reg <= i_timeout;
        tmo_cnt_reg <= '0;
      end
      wait_cnt_reg <= (state_reg == S_WAIT) ? wait_cnt_reg + W'(1) : '0;
      if ((state_reg == S_WAIT) && !i_abort && !fire_edge && timeout_hit)
        tmo_cnt_reg <= tmo_cnt_reg + W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sweep state machine with abort taking priority over everything else.
  always_ff @(posedge i_PLL_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg      <= S_IDLE;
      rep_reg        <= '0;
      repeat_reg     <= '0;
      cool_reg       <= '0;
      cool_cnt_reg   <= '0;
      attempts_reg   <= '0;
      fired_prev_reg <= 1'b0;
    end else begin
      fired_prev_reg <= i_pulse_fired;
      if (i_abort) begin
        state_reg <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              state_reg    <= S_LOAD;
              rep_reg      <= '0;
              attempts_reg <= '0;
              repeat_reg   <= (i_repeat == '0) ? REP_W'(1) : i_repeat;
              cool_reg     <= i_cooldown;
            end
          end
          S_LOAD: state_reg <= S_ARM;
          S_ARM:  state_reg <= S_WAIT;
          S_WAIT: begin
            if (fire_edge || timeout_hit) begin
              if (fire_edge)
                attempts_reg <= attempts_reg + W'(1);
              rep_reg      <= rep_reg + REP_W'(1);
              cool_cnt_reg <= '0;
              state_reg    <= S_COOL;
            end
          end
          S_COOL: begin
            if (cool_cnt_reg == cool_reg)
              state_reg <= (rep_reg < repeat_reg) ? S_ARM : S_NEXT;
            else
              cool_cnt_reg <= cool_cnt_reg + COOL_W'(1);
          end
          S_NEXT: begin
            rep_reg   <= '0;
            state_reg <= (delay_wrap && dur_wrap) ? S_DONE : S_LOAD;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  // Engine controls decode straight from state so an async reset drops them at once.
  assign o_load     = (state_reg == S_LOAD);
  assign o_arm      = (state_reg == S_ARM) || (state_reg == S_WAIT);
  assign o_busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign o_done     = (state_reg == S_DONE);
  assign o_attempts = attempts_reg;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Self-checking bench for glitch_sweep_sequencer (optional GLITCH_SWEEP_TIMEOUT_EN).
module tb_glitch_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [31:0] i_delay_start = '0, i_delay_end = '0, i_delay_step = '0;
  logic [31:0] i_dur_start = '0, i_dur_end = '0, i_dur_step = '0;
  logic [7:0]  i_repeat = '0;
  logic [15:0] i_cooldown = '0;
  logic        i_pulse_fired;
  logic [31:0] o_glitch_delay, o_glitch_duration, o_attempts;
  logic        o_load, o_arm, o_busy, o_done;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
  logic [31:0] i_timeout = '0;
  logic [31:0] o_timeout_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Engine model: auto mode fires eng_lat cycles after arm; manual mode drives man_fire.
  logic eng_mode = 1'b0;
  logic man_fire = 1'b0;
  logic auto_fire = 1'b0;
  int   eng_lat = 5;
  int   eng_cnt = 0;
  assign i_pulse_fired = eng_mode ? man_fire : auto_fire;

  // Load-strobe recorder.
  int          load_cnt = 0;
  logic [31:0] rec_d[16];
  logic [31:0] rec_u[16];

  always #5 clk = ~clk;

  glitch_sweep_sequencer dut (
    .i_PLL_Clk         (clk),
    .i_Rst_L           (rst_l),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_delay_start     (i_delay_start),
    .i_delay_end       (i_delay_end),
    .i_delay_step      (i_delay_step),
    .i_dur_start       (i_dur_start),
    .i_dur_end         (i_dur_end),
    .i_dur_step        (i_dur_step),
    .i_repeat          (i_repeat),
    .i_cooldown        (i_cooldown),
    .i_pulse_fired     (i_pulse_fired),
`ifdef GLITCH_SWEEP_TIMEOUT_EN
    .i_timeout         (i_timeout),
    .o_timeout_cnt     (o_timeout_cnt),
`endif
    .o_glitch_delay    (o_glitch_delay),
    .o_glitch_duration (o_glitch_duration),
    .o_load            (o_load),
    .o_arm             (o_arm),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_attempts        (o_attempts)
  );

  // Engine model, driven on the falling edge.
  always @(negedge clk) begin
    if (!o_arm) begin
      eng_cnt   = 0;
      auto_fire = 1'b0;
    end else if (!auto_fire) begin
      eng_cnt = eng_cnt + 1;
      if (eng_cnt >= eng_lat) auto_fire = 1'b1;
    end
  end

  // Record every load strobe with the point it delivers.
  always @(negedge clk) begin
    if (o_load) begin
      if (load_cnt < 16) begin
        rec_d[load_cnt] = o_glitch_delay;
        rec_u[load_cnt] = o_glitch_duration;
      end
      load_cnt = load_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_cnt = 0;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    // Scramble the configuration: the running sweep must use its shadow copy.
    i_delay_start = 32'hDEAD_0001; i_delay_end = 32'h0000_0002; i_delay_step = 32'h0;
    i_dur_start   = 32'hBEEF_0003; i_dur_end   = 32'h0000_0004; i_dur_step   = 32'h0;
    i_repeat      = 8'd9;          i_cooldown  = 16'd7;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] ds, de, dst, us, ue, ust;
    logic [7:0]  rep;
    logic [15:0] cool;
    int          lat;
    int          n_loads;
    logic [31:0] attempts;
    logic [31:0] exp_d[6];
    logic [31:0] exp_u[6];
  } vec_t;

  vec_t vecs[4];

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    vecs[0].name = "step2";   vecs[0].ds = 10; vecs[0].de = 14; vecs[0].dst = 2;
    vecs[0].us = 3; vecs[0].ue = 3; vecs[0].ust = 1; vecs[0].rep = 1; vecs[0].cool = 0;
    vecs[0].lat = 5; vecs[0].n_loads = 3; vecs[0].attempts = 3;
    vecs[0].exp_d = '{10, 12, 14, 0, 0, 0}; vecs[0].exp_u = '{3, 3, 3, 0, 0, 0};

    vecs[1].name = "grid";    vecs[1].ds = 0; vecs[1].de = 1; vecs[1].dst = 1;
    vecs[1].us = 5; vecs[1].ue = 7; vecs[1].ust = 1; vecs[1].rep = 2; vecs[1].cool = 3;
    vecs[1].lat = 3; vecs[1].n_loads = 6; vecs[1].attempts = 12;
    vecs[1].exp_d = '{0, 1, 0, 1, 0, 1}; vecs[1].exp_u = '{5, 5, 6, 6, 7, 7};

    vecs[2].name = "carry";   vecs[2].ds = 32'hFFFF_FFF0; vecs[2].de = 32'hFFFF_FFFF;
    vecs[2].dst = 32'h10; vecs[2].us = 1; vecs[2].ue = 2; vecs[2].ust = 1;
    vecs[2].rep = 1; vecs[2].cool = 0; vecs[2].lat = 2; vecs[2].n_loads = 2; vecs[2].attempts = 2;
    vecs[2].exp_d = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 0, 0, 0}; vecs[2].exp_u = '{1, 2, 0, 0, 0, 0};

    vecs[3].name = "zerostep"; vecs[3].ds = 5; vecs[3].de = 7; vecs[3].dst = 0;
    vecs[3].us = 9; vecs[3].ue = 4; vecs[3].ust = 3; vecs[3].rep = 0; vecs[3].cool = 1;
    vecs[3].lat = 4; vecs[3].n_loads = 3; vecs[3].attempts = 3;
    vecs[3].exp_d = '{5, 6, 7, 0, 0, 0}; vecs[3].exp_u = '{9, 9, 9, 0, 0, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_arm",      32'(o_arm), 0);
    check("rst_load",     32'(o_load), 0);
    check("rst_busy",     32'(o_busy), 0);
    check("rst_done",     32'(o_done), 0);
    check("rst_attempts", o_attempts, 0);
    check("rst_delay",    o_glitch_delay, 0);
    rst_l = 1'b1;
    @(negedge clk);

    // Table-driven full sweeps.
    for (int v = 0; v < 4; v++) begin
      i_delay_start = vecs[v].ds; i_delay_end = vecs[v].de; i_delay_step = vecs[v].dst;
      i_dur_start   = vecs[v].us; i_dur_end   = vecs[v].ue; i_dur_step   = vecs[v].ust;
      i_repeat      = vecs[v].rep; i_cooldown = vecs[v].cool;
      eng_lat       = vecs[v].lat;
      pulse_start();
      wait_done(5000, ok);
      check({vecs[v].name, "_finished"}, 32'(ok), 1);
      check({vecs[v].name, "_loads"}, 32'(load_cnt), 32'(vecs[v].n_loads));
      for (int p = 0; p < vecs[v].n_loads && p < 6; p++) begin
        check($sformatf("%s_pt%0d_delay", vecs[v].name, p), rec_d[p], vecs[v].exp_d[p]);
        check($sformatf("%s_pt%0d_dur", vecs[v].name, p), rec_u[p], vecs[v].exp_u[p]);
      end
      check({vecs[v].name, "_attempts"}, o_attempts, vecs[v].attempts);
      check({vecs[v].name, "_busy"}, 32'(o_busy), 0);
      check({vecs[v].name, "_arm"}, 32'(o_arm), 0);
      check({vecs[v].name, "_hold_delay"}, o_glitch_delay, vecs[v].exp_d[vecs[v].n_loads-1]);
      check({vecs[v].name, "_hold_dur"}, o_glitch_duration, vecs[v].exp_u[vecs[v].n_loads-1]);
      $display("sweep %s: loads=%0d attempts=%0d done=%0b", vecs[v].name, load_cnt, o_attempts, o_done);
    end

    // Abort during WAIT at attempt 3.
    i_delay_start = 0; i_delay_end = 100; i_delay_step = 1;
    i_dur_start = 0; i_dur_end = 0; i_dur_step = 1; i_repeat = 1; i_cooldown = 2;
    eng_lat = 5;
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (o_attempts == 3 && o_arm) begin ok = 1'b1; break; end
    end
    check("abort_reach_att3", 32'(ok), 1);
    repeat (2) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_arm",      32'(o_arm), 0);
    check("abort_busy",     32'(o_busy), 0);
    check("abort_done",     32'(o_done), 0);
    check("abort_attempts", o_attempts, 3);
    $display("abort: arm=%0b busy=%0b attempts=%0d", o_arm, o_busy, o_attempts);

    // Abort and start together: abort wins.
    i_delay_start = 20; i_delay_end = 21; i_delay_step = 1;
    i_dur_start = 4; i_dur_end = 4; i_dur_step = 1; i_repeat = 1; i_cooldown = 0;
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    check("abort_start_busy", 32'(o_busy), 0);
    check("abort_start_load", 32'(o_load), 0);
    $display("abort+start: busy=%0b load=%0b", o_busy, o_load);

    // Fresh start restarts from the start values.
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("restart_load",     32'(o_load), 1);
    check("restart_delay",    o_glitch_delay, 20);
    check("restart_attempts", o_attempts, 0);
    $display("restart: load=%0b delay=%0d attempts=%0d", o_load, o_glitch_delay, o_attempts);

    // Asynchronous reset mid-attempt drops arm/load immediately.
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_arm) begin ok = 1'b1; break; end
    end
    check("areset_reach_arm", 32'(ok), 1);
    #2 rst_l = 1'b0;
    #1;
    check("areset_arm",  32'(o_arm), 0);
    check("areset_load", 32'(o_load), 0);
    check("areset_busy", 32'(o_busy), 0);
    $display("async reset: arm=%0b load=%0b busy=%0b", o_arm, o_load, o_busy);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    // Pulse level already high before ARM; mid-sweep start ignored.
    eng_mode = 1'b1; man_fire = 1'b1;
    i_delay_start = 1; i_delay_end = 1; i_delay_step = 1;
    i_dur_start = 1; i_dur_end = 1; i_dur_step = 1; i_repeat = 1; i_cooldown = 0;
    pulse_start();
    repeat (10) @(negedge clk);
    check("highlvl_attempts", o_attempts, 0);
    check("highlvl_arm",      32'(o_arm), 1);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    check("busy_start_busy",  32'(o_busy), 1);
    check("busy_start_loads", 32'(load_cnt), 1);
    check("busy_start_arm",   32'(o_arm), 1);
    man_fire = 1'b0;
    @(negedge clk);
    man_fire = 1'b1;
    @(negedge clk);
    check("refire_attempts", o_attempts, 1);
    check("refire_arm",      32'(o_arm), 0);
    wait_done(100, ok);
    check("refire_done", 32'(ok), 1);
    $display("held-high: attempts=%0d done=%0b loads=%0d", o_attempts, o_done, load_cnt);
    man_fire = 1'b0;

`ifdef GLITCH_SWEEP_TIMEOUT_EN
    // Engine never fires: each attempt expires on the timeout.
    i_delay_start = 7; i_delay_end = 7; i_delay_step = 1;
    i_dur_start = 8; i_dur_end = 8; i_dur_step = 1; i_repeat = 2; i_cooldown = 0;
    i_timeout = 100;
    pulse_start();
    wait_done(1000, ok);
    check("tmo_done",     32'(ok), 1);
    check("tmo_count",    o_timeout_cnt, 2);
    check("tmo_attempts", o_attempts, 0);
    $display("timeout: tmo_cnt=%0d attempts=%0d done=%0b", o_timeout_cnt, o_attempts, o_done);
`endif
    eng_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/glitch_sweep_sequencer.md
Name: glitch_sweep_sequencer

Overview:
Sweeps the glitch engine's (delay, duration) parameter space in the i_PLL_Clk domain, with no host involvement per attempt. For each point it loads values into the pulse engine, arms it, waits for the pulse-fired indication, applies a cool-down, then repeats or advances. It sits between the host register file and the glitch pulse engine and owns the engine's arm/load controls while a sweep runs.

Parameters:
W, 32, width of delay/duration values and step operands
REP_W, 8, width of the per-point repeat count
COOL_W, 16, width of the cool-down counter

Ports:
i_PLL_Clk  in  1  fast PLL clock; all logic is in this domain
i_Rst_L  in  1  reset, asynchronous, active-low
i_start  in  1  single-cycle pulse; begin a sweep; ignored unless IDLE or DONE
i_abort  in  1  single-cycle pulse; stop the sweep; go to IDLE
i_delay_start / i_delay_end / i_delay_step  in  W each  delay axis
i_dur_start / i_dur_end / i_dur_step  in  W each  duration axis
i_repeat  in  REP_W  attempts per point; 0 is treated as 1
i_cooldown  in  COOL_W  idle cycles after each fired pulse
i_pulse_fired  in  1  level from the engine; rising edge marks pulse complete
o_glitch_delay  out  W  current delay value
o_glitch_duration  out  W  current duration value
o_load  out  1  one-cycle strobe; engine latches o_glitch_delay/o_glitch_duration
o_arm  out  1  level; engine armed
o_busy  out  1  high in every state except IDLE and DONE
o_done  out  1  high in DONE
o_attempts  out  W  total pulses fired in this sweep; wraps at 2^W

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal counters 0.
- All configuration inputs are sampled into shadow registers on the accepted i_start. Changing inputs mid-sweep has no effect.
- Zero steps: a step of 0 is treated as 1. If start > end on an axis, that axis has a single point at its start value.
- States: IDLE, LOAD, ARM, WAIT, COOL, NEXT, DONE.
- IDLE/DONE + i_start -> LOAD:
  - delay = delay_start, duration = dur_start
  - rep = 0, o_attempts = 0
  - o_done clears in the same cycle the state leaves DONE.
- LOAD: o_load = 1 for exactly one cycle -> ARM.
- ARM: o_arm goes to 1 on entry and stays high through WAIT -> WAIT next cycle.
- WAIT: on a detected rising edge of i_pulse_fired, o_arm goes to 0, o_attempts increments and rep increments -> COOL.
  - Edge detection uses a registered previous value. A level that is already high on entry does not count.
- COOL: counts i_cooldown cycles (0 means leave on the next cycle).
  - If rep < max(i_repeat, 1) -> ARM (values are not reloaded).
  - Otherwise -> NEXT.
- NEXT (one cycle): rep = 0.
  - The delay sum delay + step is computed W+1 bits wide.
  - If the sum ≤ delay_end with no carry: delay advances -> LOAD.
  - Otherwise delay = delay_start and duration advances by the same rule. If duration also overflows its end -> DONE; else -> LOAD.
- Ordering: the delay axis is the inner loop and the duration axis is the outer loop.
- DONE: o_done = 1, o_arm = 0. Outputs hold the last point.
- Abort: i_abort in any state -> IDLE next cycle, with o_arm = 0 and o_load = 0. o_attempts is kept.
  - If i_abort and i_start are high in the same cycle, abort wins.
- i_start while busy is ignored.
- An async reset mid-sweep immediately drops o_arm and o_load.

Optional Feature:
GLITCH_SWEEP_TIMEOUT_EN
- Defined:
  - Adds input i_timeout (W bits) and output o_timeout_cnt (W bits).
  - In WAIT, a counter runs. If it reaches i_timeout (nonzero) before the pulse edge, o_arm drops, o_timeout_cnt increments, and the attempt counts toward rep (but not toward o_attempts) -> COOL.
  - A value of 0 disables the timeout.
- Undefined: WAIT waits indefinitely and neither port exists.

Decomposition:
- Package glitch_pkg:
  - state enum (sweep_state_t)
  - widths W, REP_W, COOL_W as default constants
- Sub-module sweep_axis:
  - Holds start/end/step shadow registers and the current value.
  - Inputs: init, advance. Output: wrap.
  - Instantiated twice, once for delay and once for duration.

Test Plan:
- delay 10..14 step 2, dur 3..3, repeat 1, cooldown 0, engine fires 5 cycles after arm -> o_load strobes deliver delays 10, 12, 14; o_attempts=3; o_done asserted.
- delay 0..1 step 1, dur 5..7 step 1, repeat 2 -> point sequence (0,5)(1,5)(0,6)(1,6)(0,7)(1,7); o_attempts=12; exactly 6 o_load pulses.
- delay_start=0xFFFFFFF0, end=0xFFFFFFFF, step 0x10 -> no carry wrap; a single delay point per duration.
- i_abort during WAIT at attempt 3 -> o_arm low next cycle, IDLE, o_attempts=3; a fresh i_start restarts from the start values.
- i_pulse_fired held high before ARM -> no attempt is counted until it falls and rises again; i_start pulsed mid-sweep is ignored.
- (TIMEOUT_EN) i_timeout=100, engine never fires, repeat 2, one point -> o_timeout_cnt=2, o_attempts=0, o_done.
